k005297_dmabusctrl: RTL

//  68000-side DMA bus master sequencer for the 005297 DMA data register. Each word

---
 rtl/k005297_pkg.sv | 19 +
 rtl/k005297_edgedet.sv | 20 ++
 rtl/k005297_dmabusctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/k005297_pkg.sv
// Shared definitions for the 005297 DMA bus-master sequencer: FSM states and default timeout.
package k005297_pkg;

  localparam int TMO_DEFAULT = 255;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ARMED,
    ST_REQ,
    ST_TAKE,
    ST_STRB,
    ST_WAIT,
    ST_END,
    ST_REL,
    ST_REL_LAST,
    ST_ABRT
  } state_e;

endpackage

// File: rtl/k005297_edgedet.sv
// Rising-edge detector whose history register only advances on clock-enable ticks.
module k005297_edgedet (
  input  logic i_MCLK,
  input  logic i_RST_n,
  input  logic ce,
  input  logic sig,
  output logic rise
);

  logic prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_MCLK) begin
    if (!i_RST_n) prev <= 1'b0;
    else if (ce)  prev <= sig;
  end

  assign rise = ce & sig & ~prev;

endmodule

// File: rtl/k005297_dmabusctrl.sv
// 68000-side DMA bus master: one arbitrated 16-bit bus cycle per word request from the data register.
module k005297_dmabusctrl
  import k005297_pkg::*;
#(
  parameter int ADDR_W = 23,
  parameter int CNT_W  = 12,
  parameter int TMO    = TMO_DEFAULT
) (
  input  logic              i_MCLK,
  input  logic              i_RST_n,
  input  logic              i_CLK4M_PCEN_n,
  input  logic              i_START,
  input  logic              i_DIR,
  input  logic [ADDR_W-1:0] i_START_ADDR,
  input  logic [CNT_W-1:0]  i_WORD_CNT,
  input  logic              i_WORD_RQ,
  input  logic [15:0]       i_DMATXREG,
  input  logic [15:0]       i_BUS_DIN,
  output logic [15:0]       o_DMA_DIN,
  output logic              o_DMA_ACT,
  output logic              o_BR_n,
  input  logic              i_BG_n,
  output logic              o_BGACK_n,
  input  logic              i_AS_n,
  input  logic              i_DTACK_n,
  output logic              o_AS_n,
  output logic              o_UDS_n,
  output logic              o_LDS_n,
  output logic              o_R_nW,
  output logic              o_BUS_OE,
  output logic [ADDR_W-1:0] o_ADDR,
  output logic [15:0]       o_DOUT,
  output logic              o_DONE,
  output logic              o_OVERRUN,
  output logic              o_BERR
);

  localparam int TMO_W = (TMO > 1) ? $clog2(TMO) : 1;

  state_e           state;
  logic             ce;
  logic             rq_rise;
  logic             dir_q;
  logic [CNT_W-1:0] cnt_q;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic [1:0]       pend_cnt;
  logic [1:0]       pend_next;
  logic             rq_take;

  assign ce      = ~i_CLK4M_PCEN_n;
  assign tmo_hit = (tmo_cnt == TMO_W'(TMO - 1));

  k005297_edgedet u_rq_edge (
    .i_MCLK  (i_MCLK),
    .i_RST_n (i_RST_n),
    .ce      (ce),
    .sig     (i_WORD_RQ),
    .rise    (rq_rise)
  );

  // Requests are counted up to two so a word raised before the previous END is still serviced.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    rq_take   = rq_rise && (state != ST_IDLE);
    pend_next = pend_cnt;
    if (state == ST_IDLE)
      pend_next = 2'd0;
    else if (state == ST_WAIT && i_DTACK_n && tmo_hit)
      pend_next = 2'd0;
    else if (state == ST_WAIT && !i_DTACK_n)
      pend_next = pend_cnt - 2'd1;
    if (rq_take && pend_next != 2'd2)
      pend_next = pend_next + 2'd1;
  end

  always_ff @(posedge i_MCLK) begin
    if (!i_RST_n) begin
      state     <= ST_IDLE;
      dir_q     <= 1'b0;
      cnt_q     <= '0;
      tmo_cnt   <= '0;
      pend_cnt  <= 2'd0;
      o_DMA_DIN <= 16'h0000;
      o_DMA_ACT <= 1'b0;
      o_BR_n    <= 1'b1;
      o_BGACK_n <= 1'b1;
      o_AS_n    <= 1'b1;
      o_UDS_n   <= 1'b1;
      o_LDS_n   <= 1'b1;
      o_R_nW    <= 1'b1;
      o_BUS_OE  <= 1'b0;
      o_ADDR    <= '0;
      o_DOUT    <= 16'h0000;
      o_DONE    <= 1'b0;
      o_OVERRUN <= 1'b0;
      o_BERR    <= 1'b0;
    end else if (ce) begin
      o_DONE   <= 1'b0;
      pend_cnt <= pend_next;
      if (rq_take && pend_cnt != 2'd0) o_OVERRUN <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (i_START) begin
            if (i_WORD_CNT == '0) begin
              o_DONE <= 1'b1;
            end else begin
              o_ADDR    <= i_START_ADDR;
              cnt_q     <= i_WORD_CNT;
              dir_q     <= i_DIR;
              o_OVERRUN <= 1'b0;
              o_BERR    <= 1'b0;
              o_DMA_ACT <= 1'b1;
              state     <= ST_ARMED;
            end
          end
        end
        ST_ARMED: begin
          if (pend_cnt != 2'd0) begin
            o_BR_n <= 1'b0;
            state  <= ST_REQ;
          end
        end
        ST_REQ: begin
          // Only take the bus once the previous master has finished its cycle.
          if (!i_BG_n && i_AS_n && i_DTACK_n) begin
            o_BGACK_n <= 1'b0;
            o_BR_n    <= 1'b1;
            o_BUS_OE  <= 1'b1;
            o_R_nW    <= ~dir_q;
            if (dir_q) o_DOUT <= i_DMATXREG;
            state     <= ST_TAKE;
          end
        end
        ST_TAKE: begin
          o_AS_n  <= 1'b0;
          o_UDS_n <= 1'b0;
          o_LDS_n <= 1'b0;
          tmo_cnt <= '0;
          state   <= ST_STRB;
        end
        ST_STRB: state <= ST_WAIT;
        ST_WAIT: begin
          if (!i_DTACK_n) begin
            o_AS_n  <= 1'b1;
            o_UDS_n <= 1'b1;
            o_LDS_n <= 1'b1;
            if (!dir_q) o_DMA_DIN <= i_BUS_DIN;
            o_ADDR  <= o_ADDR + ADDR_W'(1);
            cnt_q   <= cnt_q - CNT_W'(1);
            state   <= ST_END;
          end else if (tmo_hit) begin
            o_BERR    <= 1'b1;
            o_AS_n    <= 1'b1;
            o_UDS_n   <= 1'b1;
            o_LDS_n   <= 1'b1;
            o_R_nW    <= 1'b1;
            o_BUS_OE  <= 1'b0;
            o_BGACK_n <= 1'b1;
            o_DMA_ACT <= 1'b0;
            state     <= ST_ABRT;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        ST_END: begin
          o_BUS_OE  <= 1'b0;
          o_BGACK_n <= 1'b1;
          o_R_nW    <= 1'b1;
          if (cnt_q == '0) begin
            o_DMA_ACT <= 1'b0;
            o_DONE    <= 1'b1;
            state     <= ST_REL_LAST;
          end else begin
            state <= ST_REL;
          end
        end
        ST_REL:      state <= ST_ARMED;
        ST_REL_LAST: state <= ST_IDLE;
        ST_ABRT:     state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end

endmodule
